// File: rtl/apb3_master_pkg.sv
// Shared types and sizing helpers for the APB3 master.
package apb3_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb3_state_e;

    localparam int unsigned TMO_CYCLES_DEF = 256;

    function automatic int unsigned tmo_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned TMO_CNT_W_DEF = $clog2(TMO_CYCLES_DEF + 1);

endpackage

// File: rtl/apb3_if.sv
// APB3 bus signal bundle shared by masters and slaves.
interface APB3_IF #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb3_master.sv
// APB3 master: one command at a time, with an ACCESS-phase timeout.
module apb3_master
    import apb3_master_pkg::*;
#(
    parameter int unsigned APB3_AW        = 32,
    parameter int unsigned APB3_DW        = 32,
    parameter int unsigned TIMEOUT_CYCLES = TMO_CYCLES_DEF
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [APB3_AW-1:0] req_addr,
    input  logic [APB3_DW-1:0] req_wdata,
    input  logic               req_write,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [APB3_DW-1:0] rsp_rdata,
    output logic               rsp_slverr,
    output logic               rsp_timeout,
    output logic [APB3_AW-1:0] PADDR,
    output logic [APB3_DW-1:0] PWDATA,
    output logic               PWRITE,
    output logic               PSEL,
    output logic               PENABLE,
    input  logic [APB3_DW-1:0] PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int unsigned   CW       = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    apb3_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [APB3_AW-1:0] addr_q, addr_d;
    logic [APB3_DW-1:0] wdata_q, wdata_d;
    logic               write_q, write_d;
    logic [APB3_DW-1:0] rdata_q, rdata_d;
    logic               slverr_q, slverr_d;
    logic               timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        slverr_d  = slverr_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    cnt_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // Completion wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    rdata_d   = write_q ? '0 : PRDATA;
                    slverr_d  = PSLVERR;
                    timeout_d = 1'b0;
                    state_d   = ST_RESP;
                end else if (cnt_q == TMO_LAST) begin
                    rdata_d   = '0;
                    slverr_d  = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rdata_q   <= '0;
            slverr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            rdata_q   <= rdata_d;
            slverr_q  <= slverr_d;
            timeout_q <= timeout_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_slverr  = slverr_q;
    assign rsp_timeout = timeout_q;

    assign PSEL    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE = (state_q == ST_ACCESS);
    assign PADDR   = addr_q;
    assign PWDATA  = wdata_q;
    assign PWRITE  = write_q;

endmodule

// File: doc/apb3_master.md
APB3_MASTER -- requirements
Module: apb3_master

Interface
REQ-001 SHALL have parameter APB3_AW, default 32, APB3 address width.
REQ-002 SHALL have parameter APB3_DW, default 32, APB3 data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, max ACCESS-phase cycles before abort; legal range 2..65535.
REQ-004 SHALL have ports (name  direction  width  meaning):
 PCLK  in  1  single clock; all logic on rising edge
 PRESETN  in  1  reset, synchronous, active-low
 req_valid  in  1  command request valid
 req_ready  out  1  command accepted when both high
 req_addr  in  APB3_AW  target address
 req_wdata  in  APB3_DW  write data
 req_write  in  1  1=write, 0=read
 rsp_valid  out  1  response valid
 rsp_ready  in  1  response consumed when both high
 rsp_rdata  out  APB3_DW  read data; 0 for writes
 rsp_slverr  out  1  slave error or timeout
 rsp_timeout  out  1  transfer aborted by timeout
 PADDR  out  APB3_AW  APB3 address
 PWDATA  out  APB3_DW  APB3 write data
 PWRITE  out  1  APB3 direction
 PSEL  out  1  APB3 select
 PENABLE  out  1  APB3 enable
 PRDATA  in  APB3_DW  APB3 read data
 PREADY  in  1  APB3 ready
 PSLVERR  in  1  APB3 slave error

Function
REQ-005 SHALL implement FSM IDLE, SETUP, ACCESS, RESP; encoding is free.
REQ-006 IDLE: req_ready=1; on req_valid latch addr/wdata/write, go SETUP. All other states: req_ready=0.
REQ-007 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-008 ACCESS: PSEL=1, PENABLE=1; stay while PREADY=0; on PREADY=1 capture PRDATA (reads only, else 0) and PSLVERR, go RESP.
REQ-009 PADDR, PWDATA, PWRITE SHALL be driven from the latched request and stay constant from SETUP through the last ACCESS cycle; they hold their last values in IDLE and RESP.
REQ-010 Timeout counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0; when PREADY=0 in ACCESS cycle number TIMEOUT_CYCLES, go RESP with rsp_timeout=1, rsp_slverr=1, rsp_rdata=0.
REQ-011 PREADY=1 in the same cycle the timeout would fire SHALL count as normal completion (no timeout).
REQ-012 RESP: rsp_valid=1, response fields stable; on rsp_ready go IDLE. rsp_valid=0 in all other states.
REQ-013 Latency: with PREADY=1 in the first ACCESS cycle, rsp_valid SHALL rise 3 cycles after the accepting edge; maximum throughput is one transfer per 4 cycles with rsp_ready held high.
REQ-014 PSEL/PENABLE SHALL be 0 in IDLE and RESP; no back-to-back ACCESS without an intervening SETUP.
REQ-015 PRDATA/PSLVERR SHALL be ignored outside the completing ACCESS cycle.

Reset
REQ-016 PRESETN=0 sampled at a PCLK edge SHALL force IDLE, zero the counter, and drive PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout to 0.
REQ-017 Reset asserted mid-transfer SHALL drop PSEL/PENABLE at that edge without issuing a response; req_ready=1 in the first cycle after release.

Structure
REQ-018 State enum and timeout counter width constant ($clog2(TIMEOUT_CYCLES+1)) SHALL live in package apb3_master_pkg.
REQ-019 No sub-module; single module, one state register, one counter, request and response holding registers.
REQ-020 The bench SHALL connect the APB3 side through the existing APB3_IF interface.

Verification
REQ-021 Write addr=0x10, wdata=0xA5A5_0001, PREADY=1 immediately -> one SETUP cycle, one ACCESS cycle, rsp_valid 3 cycles after accept, slverr=0, rdata=0.
REQ-022 Read addr=0x04, slave holds PREADY=0 for 5 cycles then returns PRDATA=0x1234_5678 -> 6 ACCESS cycles, PADDR stable throughout, rsp_rdata=0x1234_5678.
REQ-023 Read with PSLVERR=1 at completion -> rsp_slverr=1, rsp_timeout=0.
REQ-024 TIMEOUT_CYCLES=4, PREADY stuck 0 -> exactly 4 ACCESS cycles, then rsp_timeout=1, rsp_slverr=1, PSEL=0.
REQ-025 rsp_ready=0 for 3 cycles, req_valid held high -> rsp_valid and fields stable, req_ready=0 until the response is consumed.
REQ-026 PRESETN=0 during ACCESS -> next cycle PSEL=PENABLE=0, rsp_valid=0; after release a new write completes normally.
